// File: rtl/fsm_mealy_pkg.sv
// Shared helpers for the programmable Mealy sequence detector.
// All functions are elaboration-time constant functions; nothing here
// becomes runtime logic on its own.
package fsm_mealy_pkg;

  // Longest pattern the helpers can handle.
  localparam int unsigned MAX_LEN = 16;

  // Default pattern: first-received bit is the MSB.
  localparam logic [2:0] PAT_110 = 3'b110;

  // State names for the default "110" detector (state = bits matched so far).
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_110_e;

  // Width of the state register: clog2(len), never below one bit.
  function automatic int unsigned state_width(input int unsigned len);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < len) w++;
    return w;
  endfunction

  // Pattern bit in arrival order: i = 0 is the first bit received.
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] pattern,
                                   input int unsigned        len,
                                   input int unsigned        i);
    return pattern[4'(len - 1 - i)];
  endfunction

  // True when the last j bits of s (s[0] oldest, slen bits valid) equal
  // the first j pattern bits.
  function automatic bit suffix_matches(input logic [MAX_LEN:0]   s,
                                        input int unsigned      slen,
                                        input int unsigned      j,
                                        input logic [MAX_LEN-1:0] pattern,
                                        input int unsigned      len);
    for (int unsigned m = 0; m < j; m++) begin
      if (s[5'(slen - j + m)] != pat_bit(pattern, len, m)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Completion condition: last state and the final pattern bit arrives.
  function automatic bit is_final(input int unsigned        k,
                                  input logic               b,
                                  input logic [MAX_LEN-1:0] pattern,
                                  input int unsigned        len);
    return (k == len - 1) && (b == pat_bit(pattern, len, len - 1));
  endfunction

  // Next state for (matched count k, incoming bit b) using the KMP rule:
  // length of the longest suffix of (matched prefix + b) that is still a
  // proper pattern prefix. Out-of-range states fall back to 0.
  function automatic int unsigned next_state(input int unsigned        k,
                                             input logic               b,
                                             input logic [MAX_LEN-1:0] pattern,
                                             input int unsigned        len,
                                             input bit                 overlap);
    logic [MAX_LEN:0] s;
    int unsigned      slen;
    s = '0;
    if (k >= len) return 0;

    if (is_final(k, b, pattern, len)) begin
      if (!overlap) return 0;
      // Border of the full pattern decides where the next match resumes.
      for (int unsigned i = 0; i < len; i++) s[5'(i)] = pat_bit(pattern, len, i);
      slen = len;
      for (int unsigned j = len - 1; j >= 1; j--) begin
        if (suffix_matches(s, slen, j, pattern, len)) return j;
      end
      return 0;
    end

    // Matched prefix followed by the new bit.
    for (int unsigned i = 0; i < k; i++) s[5'(i)] = pat_bit(pattern, len, i);
    s[5'(k)] = b;
    slen = k + 1;
    for (int unsigned j = k + 1; j >= 1; j--) begin
      if ((j < len) && suffix_matches(s, slen, j, pattern, len)) return j;
    end
    return 0;
  endfunction

endpackage

// File: rtl/fsm_mealy_sat_counter.sv
// 16-bit (parameterisable) saturating event counter used by the optional
// match counter of fsm_mealy_110. Present only when FSM_MEALY_110_COUNT_EN
// is defined.
`ifdef FSM_MEALY_110_COUNT_EN
module fsm_mealy_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying edges, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/fsm_mealy_110.sv
// Mealy serial sequence detector for a programmable pattern (default "110").
// detect is combinational from the state and the current bit, so downstream
// logic sees the match in the same cycle the last bit arrives.
// Optional feature macro: FSM_MEALY_110_COUNT_EN adds a saturating
// match_count[15:0] output.
module fsm_mealy_110
  import fsm_mealy_pkg::*;
#(
  parameter int unsigned            PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(PAT_110),
  parameter bit                     OVERLAP     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in,
  output logic        detect
`ifdef FSM_MEALY_110_COUNT_EN
  ,
  output logic [15:0] match_count
`endif
);

  localparam int unsigned SW      = state_width(PATTERN_LEN);
  localparam int unsigned NUM_ENC = 1 << SW;
  localparam logic [MAX_LEN-1:0] PAT16 = MAX_LEN'(PATTERN);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;

  // Constant transition and completion tables, indexed by [state][bit].
  logic [SW-1:0] ns_tbl  [NUM_ENC][2];
  logic          fin_tbl [NUM_ENC][2];

  // Fill the tables from the elaboration-time KMP function; unused
  // encodings map to state 0 with no detect.
  for (genvar k = 0; k < NUM_ENC; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int unsigned NS  = next_state(k, 1'(b), PAT16, PATTERN_LEN, OVERLAP);
      localparam bit          FIN = is_final(k, 1'(b), PAT16, PATTERN_LEN);
      assign ns_tbl[k][b]  = SW'(NS);
      assign fin_tbl[k][b] = FIN;
    end
  end

  // State register; reset discards any partial match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Mealy detect; detect is forced low while in reset.
  always_comb begin
    state_d = '0;
    detect  = 1'b0;
    if (reset) begin
      state_d = ns_tbl[state_q][in];
      detect  = fin_tbl[state_q][in];
    end
  end

`ifdef FSM_MEALY_110_COUNT_EN
  // Count every edge that consumes a completing bit.
  fsm_mealy_sat_counter #(
    .W (16)
  ) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (detect),
    .count (match_count)
  );
`endif

endmodule

// File: tb/tb_fsm_mealy_110.sv
// Bench for fsm_mealy_110: three instances (default 110, 1011 overlapping,
// 1011 non-overlapping) driven by one shared bit stream and checked against
// a history-window model of "the last N bits since the match restarted".
module tb_fsm_mealy_110;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic det_def, det_ov, det_no;
`ifdef FSM_MEALY_110_COUNT_EN
  logic [15:0] cnt_def, cnt_ov, cnt_no;
`endif

  always #5 clk = ~clk;

  fsm_mealy_110 u_def (
    .clk    (clk),
    .reset  (rst),
    .in     (din),
    .detect (det_def)
`ifdef FSM_MEALY_110_COUNT_EN
    , .match_count (cnt_def)
`endif
  );

  fsm_mealy_110 #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_ov (
    .clk    (clk),
    .reset  (rst),
    .in     (din),
    .detect (det_ov)
`ifdef FSM_MEALY_110_COUNT_EN
    , .match_count (cnt_ov)
`endif
  );

  fsm_mealy_110 #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_no (
    .clk    (clk),
    .reset  (rst),
    .in     (din),
    .detect (det_no)
`ifdef FSM_MEALY_110_COUNT_EN
    , .match_count (cnt_no)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: recent bits (newest at bit 0) and how many are valid since the
  // last restart. A match needs len-1 valid bits plus the current one.
  logic [15:0] h_def, h_ov, h_no;
  int          v_def, v_ov, v_no;
  logic [15:0] m_cnt;

  function automatic bit hit(input logic [15:0] h, input int v, input logic b,
                             input int len, input logic [15:0] pat);
    logic [15:0] w;
    logic [15:0] m;
    w = (h << 1) | 16'(b);
    m = 16'((32'd1 << len) - 32'd1);
    return (v >= len - 1) && ((w & m) == pat);
  endfunction

  // Advance the model on each consumed bit; reset empties all histories.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_def = '0; h_ov = '0; h_no = '0;
      v_def = 0;  v_ov = 0;  v_no = 0;
      m_cnt = '0;
    end else begin
      if (hit(h_def, v_def, din, 3, 16'b110) && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
      if (hit(h_no, v_no, din, 4, 16'b1011)) begin
        v_no = 0;
      end else begin
        h_no = (h_no << 1) | 16'(din);
        v_no++;
      end
      h_def = (h_def << 1) | 16'(din);
      h_ov  = (h_ov << 1) | 16'(din);
      v_def++;
      v_ov++;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("det_def", 16'(det_def), 16'(rst && hit(h_def, v_def, din, 3, 16'b110)));
      chk("det_ov",  16'(det_ov),  16'(rst && hit(h_ov,  v_ov,  din, 4, 16'b1011)));
      chk("det_no",  16'(det_no),  16'(rst && hit(h_no,  v_no,  din, 4, 16'b1011)));
`ifdef FSM_MEALY_110_COUNT_EN
      chk("cnt_def", cnt_def, m_cnt);
`endif
    end
  end

  task automatic cyc(input logic b);
    @(posedge clk);
    #1 din = b;
  endtask

  // Drive one bit and check hand-computed detects (-1 = not checked).
  task automatic lit(input logic b, input int e_def, input int e_ov, input int e_no);
    cyc(b);
    #1;
    if (e_def >= 0) chk("lit_def", 16'(det_def), 16'(e_def));
    if (e_ov  >= 0) chk("lit_ov",  16'(det_ov),  16'(e_ov));
    if (e_no  >= 0) chk("lit_no",  16'(det_no),  16'(e_no));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    din = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    // Reset state: detect low even with in high.
    din = 1'b1;
    #12;
    chk("rst_def", 16'(det_def), 16'd0);
    chk("rst_ov",  16'(det_ov),  16'd0);
    chk("rst_no",  16'(det_no),  16'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    din = 1'b0;
    chk_en = 1'b1;

    // 1,1,0 detects on the 0; then 1,0 proves return to S0.
    lit(1'b1, 0, -1, -1);
    lit(1'b1, 0, -1, -1);
    lit(1'b0, 1, -1, -1);
    lit(1'b1, 0, -1, -1);
    lit(1'b0, 0, -1, -1);

    // 1,0,1,1,0: one pulse on the final 0; 1011 matches on the 4th bit.
    do_reset();
    lit(1'b1, 0, 0, 0);
    lit(1'b0, 0, 0, 0);
    lit(1'b1, 0, 0, 0);
    lit(1'b1, 0, 1, 1);
    lit(1'b0, 1, 0, 0);

    // Extra ones keep S2; single detect on the 0.
    do_reset();
    lit(1'b1, 0, 0, 0);
    lit(1'b1, 0, 0, 0);
    lit(1'b1, 0, 0, 0);
    lit(1'b1, 0, 0, 0);
    lit(1'b0, 1, 0, 0);

    // Reset while in S2 with in=0 kills detect immediately.
    do_reset();
    lit(1'b1, 0, -1, -1);
    lit(1'b1, 0, -1, -1);
    lit(1'b0, 1, -1, -1);
    #1 rst = 1'b0;
    #1 chk("mid_rst_def", 16'(det_def), 16'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    lit(1'b0, 0, -1, -1);
    lit(1'b1, 0, -1, -1);
    lit(1'b1, 0, -1, -1);
    lit(1'b0, 1, -1, -1);

    // 1011 stream: overlap detects on bits 4 and 7, no-overlap on 4 only.
    do_reset();
    lit(1'b1, 0, 0, 0);
    lit(1'b0, 0, 0, 0);
    lit(1'b1, 0, 0, 0);
    lit(1'b1, 0, 1, 1);
    lit(1'b0, 1, 0, 0);
    lit(1'b1, 0, 0, 0);
    lit(1'b1, 0, 1, 0);

`ifdef FSM_MEALY_110_COUNT_EN
    // Three matches count to 3; a forced all-ones value saturates.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1); cyc(1'b1); cyc(1'b0);
    end
    cyc(1'b0);
    #1 chk("cnt_three", cnt_def, 16'd3);
    force u_def.u_cnt.count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1 release u_def.u_cnt.count;
    cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);
    #1 chk("cnt_sat", cnt_def, 16'hFFFF);
`endif

    // Random streams with occasional resets; first half balanced, then
    // biased toward ones to exercise long runs of 1s.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (i < 2000) din = 1'($urandom_range(0, 1));
      else          din = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_mealy_110.md
Name: fsm_mealy_110

Overview:
- Mealy-type serial sequence detector. Watches a 1-bit input stream, one bit per clock, and flags the cycle in which the final bit of a programmable pattern arrives.
- Default pattern is "110", first-received bit first.
- Used as a leaf block on serial control/data lines. The detect pulse feeds downstream logic in the same cycle.

Parameters:
- PATTERN_LEN, 3, number of bits in the pattern; legal range 2..16.
- PATTERN, 3'b110, pattern value. PATTERN[PATTERN_LEN-1] is the first bit received; PATTERN[0] is the last.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = matcher restarts from empty after each match.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in  input  1  serial data bit, sampled on rising clk.
- detect  output  1  Mealy match flag, combinational from state and in.

Behaviour:
- State encoding: state = number of pattern bits currently matched, 0..PATTERN_LEN-1. Binary encoded, width clog2(PATTERN_LEN), minimum 1 bit.
- For the default pattern, states are S0 (nothing), S1 ("1"), S2 ("11").
- Reset: reset low asynchronously forces state to 0. detect is 0 while reset is low, regardless of in. Reset asserted mid-sequence discards the partial match.
- Expected bit: in state k, the expected bit is PATTERN[PATTERN_LEN-1-k].
- Match on a non-final bit: if in equals the expected bit and k < PATTERN_LEN-1, next state is k+1.
- Mismatch: next state = length of the longest proper suffix of (matched prefix followed by in) that is also a pattern prefix (KMP failure rule).
  - Transition table is computed at elaboration by a constant function; no runtime table.
- Completion: if k = PATTERN_LEN-1 and in equals PATTERN[0], detect = 1 in that same cycle, combinationally, before the clock edge.
  - Next state with OVERLAP=1: longest proper suffix of the full pattern that is also a pattern prefix.
  - Next state with OVERLAP=0: state 0.
- Default 110 transitions:
  - S0: in=1 -> S1; in=0 -> S0.
  - S1: in=1 -> S2; in=0 -> S0.
  - S2: in=1 -> S2; in=0 -> S0 with detect=1.
  - For 110, OVERLAP has no effect.
- Latency: zero cycles from the final pattern bit to detect.
- detect is high only while state and in satisfy the completion condition. Downstream logic samples it on the same rising edge that consumes the bit.
- Unreachable state encodings go to state 0 on the next clock, with detect = 0.
- X on in: no requirement beyond the reset behaviour.

Optional Feature:
- Macro: FSM_MEALY_110_COUNT_EN.
- When defined:
  - Adds output match_count [15:0].
  - Increments on each rising edge where detect = 1.
  - Saturates at 16'hFFFF.
  - Clears asynchronously to 0 while reset is low.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package fsm_mealy_pkg holds:
  - the constant function next_state(k, bit, PATTERN, PATTERN_LEN, OVERLAP);
  - a function returning the state-width constant;
  - the default pattern constant PAT_110 = 3'b110.
- No sub-module in the base block.
- With the count feature, a sub-module fsm_mealy_sat_counter (16-bit saturating counter) is natural.

Test Plan:
- Reset, then 1,1,0 on successive clocks -> detect=1 exactly during the third bit (in=0, state S2); 0 elsewhere; state returns to S0.
- 1,0,1,1,0 -> detect=0 through the first four bits, detect=1 on the final 0; exactly one pulse.
- Overlap run 1,1,1,1,0 -> state stays S2 through the extra 1s; a single detect on the 0.
- Reset low while in state S2 with in=0 -> detect drops to 0 immediately and state becomes S0. After release, 0 -> no detect; then 1,1,0 -> detect.
- PATTERN_LEN=4, PATTERN=4'b1011, stream 1,0,1,1,0,1,1:
  - OVERLAP=1 -> detect on the 4th and 7th bits.
  - OVERLAP=0 -> detect on the 4th bit only.
- With FSM_MEALY_110_COUNT_EN, three 110 matches -> match_count=3. Forcing the counter to 16'hFFFF and applying another match -> stays 16'hFFFF.
